// File: rtl/mips_pkg.sv
// Shared definitions for the simplified MIPS core: fetch FSM states,
// instruction memory geometry and the bubble encoding.
package mips_pkg;

    typedef enum logic {RUN, HALT} fetch_state_t;

    localparam int INSTR_WIDTH = 32;
    localparam int MEM_WORDS   = 32;
    localparam int PC_STEP     = 4;
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of signals between the fetch stage and its neighbours: hazard/redirect
// controls, the instruction memory port and the IF/ID outputs.
interface fetch_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  Stall;
    logic                  Branch_taken;
    logic [ADDR_WIDTH-1:0] Branch_target;
    logic                  Jump;
    logic [ADDR_WIDTH-1:0] Jump_target;
    logic [ADDR_WIDTH-1:0] Read_address;
    logic [DATA_WIDTH-1:0] Instruction;
    logic [DATA_WIDTH-1:0] IFID_instruction;
    logic [ADDR_WIDTH-1:0] IFID_pc_plus4;
    logic                  IFID_valid;
    logic                  Halted;
    logic [15:0]           Fetch_count;

    modport master (
        input  Stall, Branch_taken, Branch_target, Jump, Jump_target, Instruction,
        output Read_address, IFID_instruction, IFID_pc_plus4, IFID_valid,
               Halted, Fetch_count
    );

    modport slave (
        output Stall, Branch_taken, Branch_target, Jump, Jump_target, Instruction,
        input  Read_address, IFID_instruction, IFID_pc_plus4, IFID_valid,
               Halted, Fetch_count
    );
endinterface

// File: rtl/fetch_unit_ifid_reg.sv
// IF/ID pipeline register. Flush inserts a bubble, load captures a new
// instruction, clrValid only drops the valid bit; otherwise everything holds.
module ifid_reg
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = INSTR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  flush_i,
    input  logic                  clrValid_i,
    input  logic [DATA_WIDTH-1:0] instr_i,
    input  logic [ADDR_WIDTH-1:0] pcPlus4_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] pcPlus4_o,
    output logic                  valid_o
);

    logic [DATA_WIDTH-1:0] instr_q;
    logic [ADDR_WIDTH-1:0] pcPlus4_q;
    logic                  valid_q;

    // A flushed slot keeps its stale PC+4; only the instruction and valid are cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q   <= '0;
            pcPlus4_q <= '0;
            valid_q   <= 1'b0;
        end else if (flush_i) begin
            instr_q <= DATA_WIDTH'(NOP_INSTR);
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q   <= instr_i;
            pcPlus4_q <= pcPlus4_i;
            valid_q   <= 1'b1;
        end else if (clrValid_i) begin
            valid_q <= 1'b0;
        end
    end

    assign instr_o   = instr_q;
    assign pcPlus4_o = pcPlus4_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, selects the next PC (branch > jump >
// stall > sequential), halts on illegal fetch addresses and counts fetches.
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = mips_pkg::INSTR_WIDTH,
    parameter int                    MEM_WORDS  = mips_pkg::MEM_WORDS,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input logic        clk,
    input logic        rst,
    fetch_unit_if.master bus
);
    import mips_pkg::*;

    fetch_state_t          state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic [ADDR_WIDTH-1:0] pcPlus4;
    logic                  halted_q;
    logic [15:0]           fetchCount_q;
    logic                  redirect;
    logic                  advance;
    logic                  illegal;

    assign pcPlus4 = pc_q + ADDR_WIDTH'(PC_STEP);

    always_comb begin
        redirect = 1'b0;
        advance  = 1'b0;
        pc_d     = pcPlus4;
        if (state_q == RUN) begin
            if (bus.Branch_taken) begin
                redirect = 1'b1;
                pc_d     = bus.Branch_target;
            end else if (bus.Jump) begin
                redirect = 1'b1;
                pc_d     = bus.Jump_target;
            end else if (!bus.Stall) begin
                advance = 1'b1;
            end
        end
        illegal = (pc_d[1:0] != 2'b00) || ((pc_d >> 2) >= ADDR_WIDTH'(MEM_WORDS));
    end

    // On an illegal target the PC stays put so Read_address keeps pointing at the last legal word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            halted_q     <= 1'b0;
            fetchCount_q <= '0;
        end else if (redirect || advance) begin
            if (illegal) begin
                state_q  <= HALT;
                halted_q <= 1'b1;
            end else begin
                pc_q <= pc_d;
            end
            if (advance && (fetchCount_q != 16'hFFFF)) begin
                fetchCount_q <= fetchCount_q + 16'd1;
            end
        end
    end

    ifid_reg #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ifid (
        .clk       (clk),
        .rst       (rst),
        .load_i    (advance),
        .flush_i   (redirect),
        .clrValid_i(state_q == HALT),
        .instr_i   (bus.Instruction),
        .pcPlus4_i (pcPlus4),
        .instr_o   (bus.IFID_instruction),
        .pcPlus4_o (bus.IFID_pc_plus4),
        .valid_o   (bus.IFID_valid)
    );

    assign bus.Read_address = {2'b00, pc_q[ADDR_WIDTH-1:2]};
    assign bus.Halted       = halted_q;
    assign bus.Fetch_count  = fetchCount_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table for the main fetch/stall/redirect
// flow, then hand-written sequences for halt, reset-out-of-halt and reset-mid-redirect.
module tb_fetch_unit;

    localparam logic [31:0] BASE = 32'h1000_0000;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] brT;
        logic        jmp;
        logic [31:0] jT;
        logic [31:0] expRa;
        logic [31:0] expInstr;
        logic [31:0] expPc4;
        logic        chkPc;
        logic        expValid;
        logic        expHalted;
        logic [15:0] expCnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    fetch_unit dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Instruction memory: word i holds BASE + i.
    assign bus.Instruction = BASE + bus.Read_address;

    function automatic vec_t vec(input logic r, input logic s, input logic b, input logic [31:0] bt,
                                 input logic j, input logic [31:0] jt, input logic [31:0] ra,
                                 input logic [31:0] ins, input logic [31:0] p4, input logic cp,
                                 input logic v, input logic h, input logic [15:0] c);
        vec_t t;
        t.rst = r; t.stall = s; t.br = b; t.brT = bt; t.jmp = j; t.jT = jt;
        t.expRa = ra; t.expInstr = ins; t.expPc4 = p4; t.chkPc = cp;
        t.expValid = v; t.expHalted = h; t.expCnt = c;
        return t;
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst              = v.rst;
        bus.Stall        = v.stall;
        bus.Branch_taken = v.br;
        bus.Branch_target = v.brT;
        bus.Jump         = v.jmp;
        bus.Jump_target  = v.jT;
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input string field, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s %s: got %0h expected %0h", tag, field, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        cmp(tag, "Read_address", bus.Read_address, v.expRa);
        cmp(tag, "IFID_instruction", bus.IFID_instruction, v.expInstr);
        if (v.chkPc) cmp(tag, "IFID_pc_plus4", bus.IFID_pc_plus4, v.expPc4);
        cmp(tag, "IFID_valid", {31'b0, bus.IFID_valid}, {31'b0, v.expValid});
        cmp(tag, "Halted", {31'b0, bus.Halted}, {31'b0, v.expHalted});
        cmp(tag, "Fetch_count", {16'b0, bus.Fetch_count}, {16'b0, v.expCnt});
    endtask

    task automatic step(input string tag, input vec_t v);
        applyStimulus(v);
        checkOutput(tag, v);
    endtask

    vec_t table_q[$];

    initial begin
        rst = 1'b1;
        bus.Stall = 1'b0; bus.Branch_taken = 1'b0; bus.Branch_target = '0;
        bus.Jump = 1'b0; bus.Jump_target = '0;

        //                 rst stl br brT    jmp jT     RA  instr     pc4   chk v  h  cnt
        table_q.push_back(vec(1, 0, 0, 0,     0, 0,     0,  0,        0,    1, 0, 0, 0));
        table_q.push_back(vec(0, 0, 0, 0,     0, 0,     1,  BASE+0,   4,    1, 1, 0, 1));
        table_q.push_back(vec(0, 0, 0, 0,     0, 0,     2,  BASE+1,   8,    1, 1, 0, 2));
        table_q.push_back(vec(0, 1, 0, 0,     0, 0,     2,  BASE+1,   8,    1, 1, 0, 2));
        table_q.push_back(vec(0, 1, 0, 0,     0, 0,     2,  BASE+1,   8,    1, 1, 0, 2));
        table_q.push_back(vec(0, 0, 0, 0,     0, 0,     3,  BASE+2,   12,   1, 1, 0, 3));
        table_q.push_back(vec(0, 0, 0, 0,     0, 0,     4,  BASE+3,   16,   1, 1, 0, 4));
        table_q.push_back(vec(0, 1, 1, 'h10,  1, 'h40,  4,  0,        0,    0, 0, 0, 4));
        table_q.push_back(vec(0, 0, 0, 0,     0, 0,     5,  BASE+4,   'h14, 1, 1, 0, 5));
        table_q.push_back(vec(0, 0, 0, 0,     1, 'h20,  8,  0,        0,    0, 0, 0, 5));
        table_q.push_back(vec(0, 1, 0, 0,     1, 'h0C,  3,  0,        0,    0, 0, 0, 5));
        table_q.push_back(vec(0, 0, 0, 0,     0, 0,     4,  BASE+3,   'h10, 1, 1, 0, 6));
        table_q.push_back(vec(0, 0, 1, 'h78,  0, 0,     30, 0,        0,    0, 0, 0, 6));

        foreach (table_q[i]) step($sformatf("row%0d", i), table_q[i]);

        // Sequential run off the end of memory: words 30 and 31 arrive valid, then halt.
        step("seqW30",   vec(0, 0, 0, 0,   0, 0,    31, BASE+30, 'h7C, 1, 1, 0, 7));
        step("seqW31",   vec(0, 0, 0, 0,   0, 0,    31, BASE+31, 'h80, 1, 1, 1, 8));
        step("haltJump", vec(0, 0, 0, 0,   1, 0,    31, BASE+31, 'h80, 1, 0, 1, 8));
        step("haltBr",   vec(0, 1, 1, 'h8, 0, 0,    31, BASE+31, 'h80, 1, 0, 1, 8));

        // Reset leaves HALT and fetch resumes from word 0.
        step("rstHalt",  vec(1, 0, 0, 0,   0, 0,    0,  0,       0,    1, 0, 0, 0));
        step("resume",   vec(0, 0, 0, 0,   0, 0,    1,  BASE+0,  4,    1, 1, 0, 1));

        // Misaligned jump target halts with PC unchanged.
        step("misJump",  vec(0, 0, 0, 0,   1, 'h6,  1,  0,       0,    0, 0, 1, 1));
        step("misHold",  vec(0, 0, 1, 'h8, 0, 0,    1,  0,       0,    0, 0, 1, 1));

        // Reset during stall plus branch discards the redirect.
        step("rstRedir", vec(1, 1, 1, 'h40, 1, 'h20, 0, 0,       0,    1, 0, 0, 0));
        step("afterRst", vec(0, 0, 0, 0,   0, 0,    1,  BASE+0,  4,    1, 1, 0, 1));

        // Branch to word index MEM_WORDS is out of range.
        step("brRange",  vec(0, 0, 1, 'h80, 0, 0,   1,  0,       0,    0, 0, 1, 1));
        step("rangeHold",vec(0, 0, 0, 0,   0, 0,    1,  0,       0,    0, 0, 1, 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
